smag_addsub_arbiter: RTL and testbench

- Shares one sign-magnitude add/subtract unit (12-bit: bit 11 sign, bits 10:0 magnitude) among `N_REQ` requesters in the DSP core.
- Grants one request per cycle by round-robin and computes the result through the shared unit.
- Registers the result in a single-entry output stage tagged with the requester ID, with valid/ready backpressure.
- Sits between the DSP sequencing logic and the arithmetic datapath.

---
 rtl/smag_pkg.sv | 17 +
 rtl/smag_addsub_arbiter_if.sv | 30 +++
 rtl/smag_addsub.sv | 52 +++++
 rtl/smag_addsub_arbiter_chk.sv | 28 ++
 rtl/smag_addsub_arbiter.sv | 113 +++++++++++
 tb/tb_smag_addsub_arbiter.sv | 164 ++++++++++++++++
 6 files changed

// File: rtl/smag_pkg.sv
// Shared definitions for the sign-magnitude add/subtract arbiter: word width,
// opcodes, output-stage FSM states and the sign-magnitude word type.
package smag_pkg;

   localparam int SMAG_W = 12;

   localparam logic SMAG_SUB = 1'b0;
   localparam logic SMAG_ADD = 1'b1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FULL = 1'b1
   } smag_state_e;

   typedef logic [SMAG_W-1:0] smag_t;

endpackage

// File: rtl/smag_addsub_arbiter_if.sv
// Request/response bundle between the DSP sequencers, the shared add/subtract
// arbiter and the downstream consumer.
interface smag_addsub_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int W     = 12,
   parameter int ID_W  = $clog2(N_REQ)
) ();

   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   req_op;
   logic [N_REQ*W-1:0] req_a;
   logic [N_REQ*W-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [ID_W-1:0]    rsp_id;
   logic [W-1:0]       rsp_data;
   logic               rsp_ovf;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
   );

endinterface

// File: rtl/smag_addsub.sv
// Combinational sign-magnitude add/subtract with magnitude saturation and
// zero normalisation (a -0 result is never produced).
module smag_addsub
   import smag_pkg::*;
#(
   parameter int W = SMAG_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         op,
   output logic [W-1:0] res,
   output logic         ovf
);

   logic         sa_s;
   logic         sb_s;
   logic         sy_s;
   logic [W-2:0] ma_s;
   logic [W-2:0] mb_s;
   logic [W-2:0] my_s;
   logic [W-1:0] sum_s;

   // Subtraction flips the sign of B; the guard bit of the sum flags overflow.
   always_comb begin
      sa_s  = a[W-1];
      sb_s  = b[W-1] ^ (op == SMAG_SUB);
      ma_s  = a[W-2:0];
      mb_s  = b[W-2:0];
      sum_s = {1'b0, ma_s} + {1'b0, mb_s};
      sy_s  = 1'b0;
      my_s  = {(W-1){1'b0}};
      ovf   = 1'b0;
      if (sa_s == sb_s) begin
         sy_s = sa_s;
         if (sum_s[W-1]) begin
            my_s = {(W-1){1'b1}};
            ovf  = 1'b1;
         end else begin
            my_s = sum_s[W-2:0];
            ovf  = 1'b0;
         end
      end else if (ma_s >= mb_s) begin
         my_s = ma_s - mb_s;
         sy_s = sa_s;
      end else begin
         my_s = mb_s - ma_s;
         sy_s = sb_s;
      end
      res = {sy_s & (|my_s), my_s};
   end

endmodule

// File: rtl/smag_addsub_arbiter_chk.sv
// Protocol checker for the arbiter: single grant, and a stalled response holds
// steady while blocking all new grants.
module smag_addsub_arbiter_chk #(
   parameter int N_REQ = 4,
   parameter int W     = 12,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input logic             clk,
   input logic             rst_n,
   input logic [N_REQ-1:0] req_ready,
   input logic             rsp_valid,
   input logic             rsp_ready,
   input logic [ID_W-1:0]  rsp_id,
   input logic [W-1:0]     rsp_data,
   input logic             rsp_ovf
);

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));

   a_stall_blocks: assert property (@(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |-> (req_ready == {N_REQ{1'b0}}));

   a_stall_holds: assert property (@(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=>
         (rsp_valid && $stable(rsp_id) && $stable(rsp_data) && $stable(rsp_ovf)));

endmodule

// File: rtl/smag_addsub_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude add/subtract unit among
// N_REQ requesters, with a single-entry registered, ID-tagged output stage.
module smag_addsub_arbiter
   import smag_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = SMAG_W,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input logic                clk,
   input logic                rst_n,
   smag_addsub_arbiter_if.slave bus
);

   smag_state_e      state_r;
   logic [ID_W-1:0]  rr_ptr_r;
   logic             rsp_valid_r;
   logic [ID_W-1:0]  rsp_id_r;
   logic [W-1:0]     rsp_data_r;
   logic             rsp_ovf_r;

   logic [ID_W-1:0]  winner_s;
   logic [ID_W-1:0]  next_ptr_s;
   logic             found_s;
   logic             grant_en_s;
   logic             accept_s;
   logic [N_REQ-1:0] req_ready_s;
   logic [W-1:0]     op_a_s;
   logic [W-1:0]     op_b_s;
   logic             op_s;
   logic [W-1:0]     res_s;
   logic             ovf_s;

   // Cyclic search from rr_ptr: scanning downward lets the nearest hit win last.
   always_comb begin
      int idx;
      idx      = 0;
      winner_s = rr_ptr_r;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx      = int'(rr_ptr_r) + k;
         idx      = (idx >= N_REQ) ? (idx - N_REQ) : idx;
         winner_s = bus.req_valid[idx] ? ID_W'(idx) : winner_s;
      end
      found_s    = |bus.req_valid;
      grant_en_s = rst_n && ((state_r == IDLE) || bus.rsp_ready);
      accept_s   = grant_en_s && found_s;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready_s[i] = accept_s && (winner_s == ID_W'(i));
      end
      next_ptr_s = (winner_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : (winner_s + ID_W'(1));
   end

   // Winner's operands feed the single shared arithmetic unit.
   always_comb begin
      op_a_s = bus.req_a[winner_s*W +: W];
      op_b_s = bus.req_b[winner_s*W +: W];
      op_s   = bus.req_op[winner_s];
   end

   smag_addsub #(
      .W (W)
   ) u_addsub (
      .a   (op_a_s),
      .b   (op_b_s),
      .op  (op_s),
      .res (res_s),
      .ovf (ovf_s)
   );

   // Output-stage FSM: a FULL stage may retire and reload on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         rr_ptr_r    <= {ID_W{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= {ID_W{1'b0}};
         rsp_data_r  <= {W{1'b0}};
         rsp_ovf_r   <= 1'b0;
      end else begin
         if (accept_s) begin
            rr_ptr_r    <= next_ptr_s;
            rsp_id_r    <= winner_s;
            rsp_data_r  <= res_s;
            rsp_ovf_r   <= ovf_s;
         end
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r     <= FULL;
                  rsp_valid_r <= 1'b1;
               end
            end
            FULL: begin
               if (bus.rsp_ready && !accept_s) begin
                  state_r     <= IDLE;
                  rsp_valid_r <= 1'b0;
               end
            end
            default: begin
               state_r     <= IDLE;
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_id    = rsp_id_r;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.rsp_ovf   = rsp_ovf_r;

endmodule

// File: tb/tb_smag_addsub_arbiter.sv
// Directed-vector bench for smag_addsub_arbiter with hand-computed results.
module tb_smag_addsub_arbiter;
   import smag_pkg::*;

   localparam int N_REQ = 4;
   localparam int W     = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [11:0] exp_data [4];
   logic        exp_ovf  [4];

   always #5 clk = ~clk;

   smag_addsub_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

   smag_addsub_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   smag_addsub_arbiter_chk #(.N_REQ(N_REQ), .W(W)) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_ready (bus.req_ready),
      .rsp_valid (bus.rsp_valid),
      .rsp_ready (bus.rsp_ready),
      .rsp_id    (bus.rsp_id),
      .rsp_data  (bus.rsp_data),
      .rsp_ovf   (bus.rsp_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic op, input logic [11:0] a, input logic [11:0] b);
      bus.req_op[i]       = op;
      bus.req_a[i*W +: W] = a;
      bus.req_b[i*W +: W] = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic v, input int id,
                            input logic [11:0] d, input logic o);
      check({tag, "_valid"}, 32'(bus.rsp_valid), 32'(v));
      check({tag, "_id"},    32'(bus.rsp_id),    32'(id));
      check({tag, "_data"},  32'(bus.rsp_data),  32'(d));
      check({tag, "_ovf"},   32'(bus.rsp_ovf),   32'(o));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got 0x0 exp 0x1");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.req_valid = 4'h0;
      bus.req_op    = 4'h0;
      bus.req_a     = 48'h0;
      bus.req_b     = 48'h0;
      bus.rsp_ready = 1'b0;

      // Reset state, requests must not be granted while in reset
      #2 bus.req_valid = 4'hF;
      #1 check("rst_ready", 32'(bus.req_ready), 32'h0);
      check_rsp("rst", 1'b0, 0, 12'h000, 1'b0);
      bus.req_valid = 4'h0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();

      // Plain subtraction on requester 0
      set_req(0, SMAG_SUB, 12'h00A, 12'h003);
      bus.req_valid = 4'b0001;
      bus.rsp_ready = 1'b1;
      #1 check("t1_ready", 32'(bus.req_ready), 32'h1);
      tick();
      check_rsp("t1", 1'b1, 0, 12'h007, 1'b0);

      // Negative result, then -0 minus +0 must give +0
      set_req(2, SMAG_SUB, 12'h003, 12'h00A);
      bus.req_valid = 4'b0100;
      #1 check("t2_ready", 32'(bus.req_ready), 32'h4);
      tick();
      check_rsp("t2a", 1'b1, 2, 12'h807, 1'b0);
      set_req(2, SMAG_SUB, 12'h800, 12'h000);
      tick();
      check_rsp("t2b", 1'b1, 2, 12'h000, 1'b0);

      // Negative overflow saturates to -2047
      set_req(1, SMAG_ADD, 12'hFFF, 12'h801);
      bus.req_valid = 4'b0010;
      tick();
      check_rsp("t3", 1'b1, 1, 12'hFFF, 1'b1);
      bus.req_valid = 4'b0000;
      tick();
      check("t3_drain", 32'(bus.rsp_valid), 32'h0);

      // Load a result, stall, then reset asynchronously mid-cycle
      set_req(3, SMAG_ADD, 12'h805, 12'h007);
      bus.req_valid = 4'b1000;
      bus.rsp_ready = 1'b0;
      tick();
      check_rsp("t6_load", 1'b1, 3, 12'h002, 1'b0);
      bus.req_valid = 4'b0000;
      #2 rst_n = 1'b0;
      #1 check_rsp("t6_rst", 1'b0, 0, 12'h000, 1'b0);
      bus.req_valid = 4'hF;
      #1 check("t6_rst_ready", 32'(bus.req_ready), 32'h0);
      tick();
      rst_n = 1'b0;
      #1 rst_n = 1'b1;

      // All requesters active: strict rotation starting from 0
      set_req(0, SMAG_ADD, 12'h001, 12'h002);
      set_req(1, SMAG_SUB, 12'h005, 12'h007);
      set_req(2, SMAG_ADD, 12'h7FF, 12'h001);
      set_req(3, SMAG_ADD, 12'h805, 12'h005);
      exp_data[0] = 12'h003; exp_ovf[0] = 1'b0;
      exp_data[1] = 12'h802; exp_ovf[1] = 1'b0;
      exp_data[2] = 12'h7FF; exp_ovf[2] = 1'b1;
      exp_data[3] = 12'h000; exp_ovf[3] = 1'b0;
      bus.rsp_ready = 1'b1;
      #1 check("t6_first_ready", 32'(bus.req_ready), 32'h1);
      for (int k = 0; k < 8; k++) begin
         tick();
         check_rsp($sformatf("t4_%0d", k), 1'b1, k % 4, exp_data[k % 4], exp_ovf[k % 4]);
      end

      // Backpressure: the held result (requester 3) stays put, no grants
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1 check($sformatf("t5_ready_%0d", k), 32'(bus.req_ready), 32'h0);
         tick();
         check_rsp($sformatf("t5_hold_%0d", k), 1'b1, 3, 12'h000, 1'b0);
      end
      bus.rsp_ready = 1'b1;
      #1 check("t5_release_ready", 32'(bus.req_ready), 32'h1);
      tick();
      check_rsp("t5_next", 1'b1, 0, 12'h003, 1'b0);
      bus.req_valid = 4'h0;
      tick();
      check("t5_drain", 32'(bus.rsp_valid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
